// File: rtl/fc_if.sv
// Bus bundle for fc_forward: weight write port, feature stream and result stream.
interface fc_if;
  logic               w_we;
  logic        [15:0] w_addr;
  logic signed [15:0] w_data;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;
  logic               busy;
  logic               res_sig;
  logic signed [15:0] result;
  logic         [7:0] res_idx;
  logic               done;

  modport master (
    output w_we, w_addr, w_data, in_valid, in_data,
    input  in_ready, busy, res_sig, result, res_idx, done
  );

  modport slave (
    input  w_we, w_addr, w_data, in_valid, in_data,
    output in_ready, busy, res_sig, result, res_idx, done
  );
endinterface

// File: rtl/fc_forward.sv
// Fully-connected layer: collects N_IN features, then runs one MAC per cycle per
// neuron and emits a saturated Q-format result every N_IN+1 cycles.
module fc_forward #(
  parameter int N_IN  = 32,
  parameter int N_OUT = 10,
  parameter int FRAC  = 8,
  parameter int RELU  = 0
) (
  input  logic clk,
  input  logic rst,
  fc_if.slave  bus
);
  localparam int NW = N_OUT * N_IN;
  localparam int AW = (NW > 1) ? $clog2(NW) : 1;
  localparam int FW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int KW = $clog2(N_IN + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_COMP = 1'b1;

  logic        [0:0]    state;
  logic        [KW-1:0] k;
  logic        [7:0]    o;
  logic signed [39:0]   acc;
  logic                 res_sig_q, done_q;
  logic signed [15:0]   result_q;
  logic        [7:0]    res_idx_q;

  logic signed [15:0] feat [N_IN];
  logic signed [15:0] wts  [NW];

  logic               last_mac, out_cyc;
  logic [FW-1:0]      k_rd;
  logic [AW-1:0]      widx;
  logic signed [31:0] prod;
  logic signed [39:0] acc_sum, shifted;
  logic signed [15:0] sat;

  // k == N_IN is the output cycle; keep reads in range there
  assign last_mac = (state == S_COMP) && (k == KW'(N_IN - 1));
  assign out_cyc  = (state == S_COMP) && (k == KW'(N_IN));
  assign k_rd     = out_cyc ? '0 : k[FW-1:0];
  assign widx     = AW'(int'(o) * N_IN + int'(k_rd));
  assign prod     = feat[k_rd] * wts[widx];
  assign acc_sum  = ((k == '0) ? 40'sd0 : acc) + 40'(prod);
  assign shifted  = acc_sum >>> FRAC;

  always_comb begin
    sat = shifted[15:0];
    if (shifted > 40'sd32767)       sat = 16'sh7fff;
    else if (shifted < -40'sd32768) sat = 16'sh8000;
    if (RELU != 0 && sat < 0)       sat = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      o         <= '0;
      acc       <= '0;
      res_sig_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      res_idx_q <= '0;
    end else begin
      res_sig_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        S_IDLE: if (bus.in_valid) begin
          if (k == KW'(N_IN - 1)) begin
            k     <= '0;
            o     <= '0;
            state <= S_COMP;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_COMP: begin
          if (out_cyc) begin
            k <= '0;
            if (o == 8'(N_OUT - 1)) state <= S_IDLE;
            else                    o     <= o + 8'd1;
          end else begin
            acc <= acc_sum;
            k   <= k + KW'(1);
            if (last_mac) begin
              res_sig_q <= 1'b1;
              result_q  <= sat;
              res_idx_q <= o;
              done_q    <= (o == 8'(N_OUT - 1));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset; it is only written while collecting features
  always_ff @(posedge clk) begin
    if (!rst && state == S_IDLE) begin
      if (bus.in_valid) feat[k[FW-1:0]] <= bus.in_data;
      if (bus.w_we && bus.w_addr < 16'(NW)) wts[bus.w_addr[AW-1:0]] <= bus.w_data;
    end
  end

  assign bus.in_ready = (state == S_IDLE);
  assign bus.busy     = (state == S_COMP);
  assign bus.res_sig  = res_sig_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.res_idx  = res_idx_q;
endmodule

// File: doc/fc_forward.md
FC_FORWARD -- requirements
Module: fc_forward

Interface
REQ-001 Parameter N_IN, default 32: number of input features per sample (conv layer-3 channel count).
REQ-002 Parameter N_OUT, default 10: number of output neurons.
REQ-003 Parameter FRAC, default 8: fractional bits of the Q-format used for features, weights and results.
REQ-004 Parameter RELU, default 0: when 1, negative results are forced to 0 after saturation.
REQ-005 clk  input  1: single clock; all logic is rising-edge.
REQ-006 rst  input  1: reset, synchronous and active-high.
REQ-007 w_we  input  1: weight write strobe.
REQ-008 w_addr  input  16: weight index, o*N_IN+k; values >= N_OUT*N_IN are ignored.
REQ-009 w_data  input  16 signed: weight value.
REQ-010 in_valid  input  1: feature word valid.
REQ-011 in_data  input  16 signed: feature word, index k in arrival order.
REQ-012 in_ready  output  1: high when the block accepts features.
REQ-013 busy  output  1: high in COMPUTE.
REQ-014 res_sig  output  1: one-cycle pulse, result valid.
REQ-015 result  output  16 signed: neuron output.
REQ-016 res_idx  output  8: neuron index o of current result.
REQ-017 done  output  1: one-cycle pulse coincident with the res_sig of neuron N_OUT-1.

Function
REQ-018 The block SHALL have states IDLE (collecting features) and COMPUTE.
REQ-019 In IDLE, in_ready SHALL be 1; each cycle with in_valid=1 SHALL store in_data at feature index k and increment k.
REQ-020 On acceptance of feature N_IN-1 (cycle t), the block SHALL enter COMPUTE at t+1 with k cleared and o=0.
REQ-021 In COMPUTE, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-022 Per neuron, the block SHALL perform N_IN MAC cycles, acc += feature[k]*w[o*N_IN+k], k=0..N_IN-1, acc cleared before k=0.
REQ-023 Products SHALL be full 32-bit signed; acc SHALL be 40-bit signed, so no accumulation overflow.
REQ-024 After the last MAC, the block SHALL spend one output cycle asserting res_sig=1 with res_idx=o and result = sat16(acc >>> FRAC), arithmetic shift (floor toward minus infinity).
REQ-025 sat16 SHALL clamp to +32767 / -32768; with RELU=1 a negative clamped value SHALL become 0.
REQ-026 Neuron o result SHALL appear in cycle t+(o+1)*(N_IN+1); no other cycle asserts res_sig.
REQ-027 After the output cycle of neuron N_OUT-1, the block SHALL return to IDLE next cycle with k=0; done SHALL pulse with that res_sig.
REQ-028 result and res_idx SHALL hold their last values between pulses.
REQ-029 Weights SHALL be stored in a register array with combinational read; writes SHALL take effect on the clock edge with w_we=1.
REQ-030 w_we SHALL be honoured only in IDLE; writes in COMPUTE SHALL be dropped.
REQ-031 Features and weights SHALL persist across samples until overwritten; a new sample overwrites features index 0 upward.
REQ-032 Simultaneous w_we and in_valid in IDLE SHALL both take effect in the same cycle.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, k=0, o=0, acc=0, in_ready=1, busy=0, res_sig=0, done=0, result=0, res_idx=0.
REQ-034 rst SHALL override all other inputs, including mid-COMPUTE; the aborted sample produces no further res_sig.
REQ-035 Weight and feature storage SHALL NOT be cleared by reset.

Verification
REQ-036 Defaults; all weights 256, 32 features of 256 -> 10 res_sig pulses, each result=8192, res_idx 0..9, first pulse 33 cycles after last feature, spacing 33, done with idx 9.
REQ-037 Neuron 3 weights -256, others 256, features 256, RELU=0 -> idx 3 result=-8192; with RELU=1 -> idx 3 result=0.
REQ-038 Features 32767, weights 32767 -> all results 32767 (saturation); weights -32768 -> all results -32768.
REQ-039 Assert rst at 10th MAC cycle of neuron 2 -> next cycle in_ready=1, busy=0, no further res_sig; re-send features -> full correct result sequence.
REQ-040 w_we with w_data=0 at w_addr 0 during COMPUTE -> ignored; next sample's neuron 0 still uses old weight 0 (result unchanged, 8192 in REQ-036 setup).
REQ-041 in_valid held high throughout COMPUTE -> no feature accepted, in_ready=0, results unaffected.
